// File: rtl/param_universal_register.sv
// Universal shift register: hold/load/shift/rotate/clear/preset with a shift-frame
// counter that pulses frame_done once every WIDTH shift or rotate operations.
module param_universal_register #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       enable,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           in,
    input  logic                       ser_in_l,
    input  logic                       ser_in_r,
    output logic [WIDTH-1:0]           out,
    output logic                       ser_out,
    output logic [$clog2(WIDTH):0]     shift_cnt,
    output logic                       frame_done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROTL = 3'b100;
    localparam logic [2:0] M_ROTR = 3'b101;
    localparam logic [2:0] M_SCLR = 3'b110;
    localparam logic [2:0] M_SPRE = 3'b111;

    logic [WIDTH-1:0] out_q, out_d;
    logic             ser_out_q, ser_out_d;
    logic [CW-1:0]    shift_cnt_q, shift_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             shift_op;
    logic             new_frame;

    always_comb begin
        out_d        = out_q;
        ser_out_d    = ser_out_q;
        shift_cnt_d  = shift_cnt_q;
        frame_done_d = 1'b0;
        shift_op     = 1'b0;
        new_frame    = 1'b0;
        if (enable) begin
            case (mode)
                M_HOLD: ;
                M_LOAD: begin
                    out_d     = in;
                    new_frame = 1'b1;
                end
                M_SHL: begin
                    out_d     = {out_q[WIDTH-2:0], ser_in_l};
                    ser_out_d = out_q[WIDTH-1];
                    shift_op  = 1'b1;
                end
                M_SHR: begin
                    out_d     = {ser_in_r, out_q[WIDTH-1:1]};
                    ser_out_d = out_q[0];
                    shift_op  = 1'b1;
                end
                M_ROTL: begin
                    out_d     = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                    ser_out_d = out_q[WIDTH-1];
                    shift_op  = 1'b1;
                end
                M_ROTR: begin
                    out_d     = {out_q[0], out_q[WIDTH-1:1]};
                    ser_out_d = out_q[0];
                    shift_op  = 1'b1;
                end
                M_SCLR: begin
                    out_d     = '0;
                    new_frame = 1'b1;
                end
                M_SPRE: begin
                    out_d     = PRESET_VALUE;
                    new_frame = 1'b1;
                end
                default: ;
            endcase
        end

        // Counter tracks operations, not displacement; the WIDTH-th one wraps and pulses.
        if (new_frame) begin
            shift_cnt_d = '0;
        end else if (shift_op) begin
            if (shift_cnt_q == LAST_CNT) begin
                shift_cnt_d  = '0;
                frame_done_d = 1'b1;
            end else begin
                shift_cnt_d = shift_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            out_q        <= RESET_VALUE;
            ser_out_q    <= 1'b0;
            shift_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            ser_out_q    <= ser_out_d;
            shift_cnt_q  <= shift_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out        = out_q;
    assign ser_out    = ser_out_q;
    assign shift_cnt  = shift_cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_param_universal_register.sv
// Bench for param_universal_register: directed scenarios plus random operations
// checked against an arithmetic reference model of the register and its frame counter.
module tb_param_universal_register;

    localparam logic [7:0] RV8 = 8'h5A;

    logic        clk;
    logic        clear;
    logic        enable;
    logic [2:0]  mode;
    logic [7:0]  din;
    logic        ser_l;
    logic        ser_r;
    logic [7:0]  dout;
    logic        sout;
    logic [3:0]  cnt;
    logic        fd;

    logic        enable2;
    logic [2:0]  mode2;
    logic [15:0] din2;
    logic [15:0] dout2;
    logic        sout2;
    logic [4:0]  cnt2;
    logic        fd2;

    int errors = 0;
    int checks = 0;

    // Reference model state (plain integers)
    int m_out;
    int m_ser;
    int m_cnt;
    int m_fd;

    param_universal_register #(.WIDTH(8), .RESET_VALUE(RV8)) dut (
        .clk(clk), .clear(clear), .enable(enable), .mode(mode), .in(din),
        .ser_in_l(ser_l), .ser_in_r(ser_r), .out(dout), .ser_out(sout),
        .shift_cnt(cnt), .frame_done(fd)
    );

    param_universal_register #(.WIDTH(16), .RESET_VALUE(16'h0000), .PRESET_VALUE(16'hFFFF)) dut16 (
        .clk(clk), .clear(clear), .enable(enable2), .mode(mode2), .in(din2),
        .ser_in_l(1'b1), .ser_in_r(1'b0), .out(dout2), .ser_out(sout2),
        .shift_cnt(cnt2), .frame_done(fd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = int'(RV8);
        m_ser = 0;
        m_cnt = 0;
        m_fd  = 0;
    endtask

    task automatic model_step(input logic en, input logic [2:0] md, input logic [7:0] d,
                              input logic sl, input logic sr);
        int old;
        bit counted;
        old     = m_out;
        counted = 0;
        m_fd    = 0;
        if (en) begin
            case (md)
                3'd1: begin m_out = int'(d); m_cnt = 0; end
                3'd2: begin m_out = (old * 2 + int'(sl)) % 256; m_ser = old / 128; counted = 1; end
                3'd3: begin m_out = old / 2 + int'(sr) * 128; m_ser = old % 2; counted = 1; end
                3'd4: begin m_out = (old * 2) % 256 + old / 128; m_ser = old / 128; counted = 1; end
                3'd5: begin m_out = old / 2 + (old % 2) * 128; m_ser = old % 2; counted = 1; end
                3'd6: begin m_out = 0; m_cnt = 0; end
                3'd7: begin m_out = 255; m_cnt = 0; end
                default: ;
            endcase
        end
        if (counted) begin
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt = 0;
                m_fd  = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out"}, 32'(dout), 32'(m_out));
        chk({tag, ".ser_out"}, 32'(sout), 32'(m_ser));
        chk({tag, ".shift_cnt"}, 32'(cnt), 32'(m_cnt));
        chk({tag, ".frame_done"}, 32'(fd), 32'(m_fd));
    endtask

    task automatic step(input logic en, input logic [2:0] md, input logic [7:0] d,
                        input logic sl, input logic sr, input string tag);
        enable = en;
        mode   = md;
        din    = d;
        ser_l  = sl;
        ser_r  = sr;
        @(posedge clk);
        model_step(en, md, d, sl, sr);
        #1;
        check_model(tag);
    endtask

    initial begin
        int fd_pulses;
        logic [7:0] rot_exp;
        clear   = 1'b0;
        enable  = 1'b1;
        mode    = 3'd2;
        din     = 8'hFF;
        ser_l   = 1'b1;
        ser_r   = 1'b1;
        enable2 = 1'b1;
        mode2   = 3'd0;
        din2    = 16'h1234;
        model_reset();

        // Reset holds despite clocks and an active mode
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        chk("reset.out_const", 32'(dout), 32'(RV8));
        chk("reset16.out", 32'(dout2), 32'h0);
        #2 clear = 1'b1;

        step(1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, "load_a5");
        chk("load_a5.cnt_const", 32'(cnt), 32'd0);

        // 8 rotations return to the start; ser_out reads out the original bits MSB first
        rot_exp = 8'b10100101;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, "rotl");
            chk($sformatf("rotl%0d.ser", i), 32'(sout), 32'(rot_exp[7 - i]));
            chk($sformatf("rotl%0d.fd", i), 32'(fd), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("rotl.out_back", 32'(dout), 32'hA5);
        step(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, "rotl_after");
        chk("rotl_after.fd", 32'(fd), 32'd0);

        // Enable gap mid-sequence
        step(1'b1, 3'd1, 8'h81, 1'b0, 1'b0, "load_81");
        fd_pulses = 0;
        step(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, "shr_a");
        fd_pulses += int'(fd);
        step(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, "shr_dis");
        fd_pulses += int'(fd);
        step(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, "shr_b");
        fd_pulses += int'(fd);
        chk("shr_gap.out", 32'(dout), 32'h20);
        chk("shr_gap.cnt", 32'(cnt), 32'd2);
        chk("shr_gap.no_fd", 32'(fd_pulses), 32'd0);

        // LOAD restarts the frame
        for (int i = 0; i < 5; i++) step(1'b1, 3'd2, 8'h00, 1'(i), 1'b0, "shl5");
        step(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0, "load_3c");
        chk("load_3c.cnt", 32'(cnt), 32'd0);
        fd_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'd3, 8'h00, 1'b1, 1'b0, "shr8");
            fd_pulses += int'(fd);
        end
        chk("shr8.fd_on_8th", 32'(fd), 32'd1);
        step(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, "shr8_hold");
        fd_pulses += int'(fd);
        chk("shr8.pulses", 32'(fd_pulses), 32'd1);

        // Asynchronous clear between edges, mid-frame
        step(1'b1, 3'd1, 8'hC3, 1'b0, 1'b0, "load_c3");
        for (int i = 0; i < 6; i++) step(1'b1, 3'd2, 8'h00, 1'b1, 1'b0, "shl6");
        #3 clear = 1'b0;
        model_reset();
        #1;
        check_model("async_clr");
        chk("async_clr.out_const", 32'(dout), 32'(RV8));
        @(posedge clk);
        #1;
        check_model("clr_held");
        #2 clear = 1'b1;
        step(1'b1, 3'd2, 8'h00, 1'b0, 1'b0, "post_clr1");
        step(1'b1, 3'd2, 8'h00, 1'b0, 1'b0, "post_clr2");
        chk("post_clr.cnt", 32'(cnt), 32'd2);
        chk("post_clr.fd", 32'(fd), 32'd0);

        // Random operations with occasional mid-cycle clears
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                #2 clear = 1'b0;
                model_reset();
                #1;
                check_model("rnd_clr");
                #1 clear = 1'b1;
            end
            step(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
                 8'($urandom), 1'($urandom), 1'($urandom), "rnd");
        end

        // WIDTH=16 instance: preset and clear after some shifts
        mode2 = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("w16.shl.cnt", 32'(cnt2), 32'd3);
        mode2 = 3'd7;
        @(posedge clk);
        #1;
        chk("w16.spre.out", 32'(dout2), 32'hFFFF);
        chk("w16.spre.cnt", 32'(cnt2), 32'd0);
        mode2 = 3'd6;
        @(posedge clk);
        #1;
        chk("w16.sclr.out", 32'(dout2), 32'h0000);
        chk("w16.sclr.cnt", 32'(cnt2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_universal_register.md
PARAM_UNIVERSAL_REGISTER -- requirements
Module: param_universal_register

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0 (WIDTH bits): value loaded into out on asynchronous reset.
REQ-003 Parameter PRESET_VALUE, default all ones (WIDTH bits): value loaded by the synchronous PRESET mode.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 clear  input  1  asynchronous, active-low reset; clear=0 forces the reset state immediately, independent of clk.
REQ-006 enable  input  1  clock qualifier; enable=0 holds all state (out, ser_out, shift_cnt) and frame_done is 0.
REQ-007 mode  input  3  operation select, decoded per REQ-011.
REQ-008 in  input  WIDTH  parallel load data.
REQ-009 ser_in_l  input  1  serial bit entering at bit 0 on shift left.
REQ-010 ser_in_r  input  1  serial bit entering at bit WIDTH-1 on shift right.
REQ-011 out  output  WIDTH  registered contents.
REQ-012 ser_out  output  1  registered copy of the last bit shifted or rotated out.
REQ-013 shift_cnt  output  clog2(WIDTH)+1  number of shift/rotate operations in the current frame.
REQ-014 frame_done  output  1  one-cycle registered pulse marking frame completion.

Function
REQ-015 Mode encoding with enable=1: 000 HOLD; 001 LOAD (out<=in); 010 SHL (out<={out[W-2:0],ser_in_l}); 011 SHR (out<={ser_in_r,out[W-1:1]}); 100 ROTL; 101 ROTR; 110 SCLR (out<=0); 111 SPRE (out<=PRESET_VALUE).
REQ-016 All modes take effect on the same rising edge; out latency is 1 cycle from sampling mode/in.
REQ-017 SHL/ROTL drive ser_out<=out[W-1]; SHR/ROTR drive ser_out<=out[0]; every other mode holds ser_out.
REQ-018 Each SHL/SHR/ROTL/ROTR increments shift_cnt by 1.
REQ-019 The shift/rotate that takes shift_cnt from WIDTH-1 to WIDTH wraps shift_cnt to 0 and sets frame_done=1 for exactly the following cycle.
REQ-020 LOAD, SCLR and SPRE reset shift_cnt to 0 and start a new frame; HOLD preserves shift_cnt.
REQ-021 frame_done is 0 in every cycle not covered by REQ-019, including consecutive frames (one pulse per WIDTH shifts).
REQ-022 Direction changes inside a frame still count; the counter tracks operations, not net displacement.
REQ-023 Undriven or X mode bits are not required to be handled; no additional mode states exist.

Reset
REQ-024 While clear=0: out=RESET_VALUE, ser_out=0, shift_cnt=0, frame_done=0, regardless of clk, enable or mode.
REQ-025 Assertion of clear mid-frame aborts the frame with no frame_done pulse; the first edge after clear deasserts treats the register as frame start.
REQ-026 Deassertion of clear is synchronous to no particular edge; the first rising clk edge with clear=1 performs a normal operation.

Verification
REQ-027 WIDTH=8: clear=0 then 1, LOAD in=8'hA5 -> out=8'hA5, shift_cnt=0, ser_out=0 after 1 cycle.
REQ-028 WIDTH=8: out=8'hA5, 8x ROTL -> out returns to 8'hA5, ser_out sequence 1,0,1,0,0,1,0,1, frame_done high only the cycle after the 8th rotate.
REQ-029 WIDTH=8: out=8'h81, SHR with ser_in_r=0 for 3 cycles with enable=0 on the 2nd -> out=8'h20, shift_cnt=2, frame_done never high.
REQ-030 WIDTH=8: 5 SHL then LOAD in=8'h3C then 8 SHR -> shift_cnt=0 after LOAD, frame_done pulses exactly once after the 8th SHR.
REQ-031 WIDTH=8: clear=0 asserted between clk edges after 6 shifts -> out=RESET_VALUE at once, shift_cnt=0, no frame_done on the next 2 shifts.
REQ-032 WIDTH=16, PRESET_VALUE=16'hFFFF: SPRE then SCLR -> out=16'hFFFF then 16'h0000, shift_cnt=0 both cycles.
